// File: rtl/cpu_defs.sv
// Shared controller definitions: opcodes, ALU codes, FSM states and ctl bit positions.
// Latency: n/a. Backpressure: n/a.
package cpu_defs;

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_ALU  = 6'h01;
  localparam logic [5:0] OP_ALUI = 6'h02;
  localparam logic [5:0] OP_MOVI = 6'h03;
  localparam logic [5:0] OP_MOV  = 6'h04;
  localparam logic [5:0] OP_LD   = 6'h05;
  localparam logic [5:0] OP_ST   = 6'h06;
  localparam logic [5:0] OP_STB  = 6'h07;
  localparam logic [5:0] OP_JMP  = 6'h08;
  localparam logic [5:0] OP_BT   = 6'h09;
  localparam logic [5:0] OP_BF   = 6'h0A;
  localparam logic [5:0] OP_OUT  = 6'h0B;
  localparam logic [5:0] OP_SW   = 6'h0C;
  localparam logic [5:0] OP_HALT = 6'h3F;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;

  typedef enum logic [2:0] {
    ST_FETCH, ST_FWAIT, ST_INCR, ST_EXEC, ST_LWAIT, ST_WB, ST_SWAIT, ST_HALT
  } state_e;

  // Bit positions inside ctl, MSB first.
  localparam int CTL_READ_IP     = 15;
  localparam int CTL_REG_WRITE   = 14;
  localparam int CTL_MEM_WRITE   = 13;
  localparam int CTL_MEM_ADDR_RG = 12;
  localparam int CTL_ALU_USE_IMM = 11;
  localparam int CTL_ALU_INCR_IP = 10;
  localparam int CTL_RW_MEM      = 9;
  localparam int CTL_B_DEST      = 8;
  localparam int CTL_RW_USE_B    = 7;
  localparam int CTL_RW_IMM      = 6;
  localparam int CTL_MEM_BYTE    = 5;
  localparam int CTL_A_SRC       = 4;
  localparam int CTL_RW_OUT      = 3;
  localparam int CTL_RW_IF_TRUE  = 2;
  localparam int CTL_RW_IF_FALSE = 1;
  localparam int CTL_READ_SWITCH = 0;

  localparam logic [4:0] REG_IP  = 5'd10;
  localparam logic [4:0] REG_OUT = 5'd12;

endpackage

// File: rtl/control_decode.sv
// Maps (next state, opcode, func) onto the datapath ctl vector and ALU opcode.
// Latency: combinational. Backpressure: none; all waiting is owned by the FSM.
module control_decode
  import cpu_defs::*;
(
  input  state_e      state,
  input  logic [5:0]  opcode,
  input  logic [3:0]  func,
  output logic [15:0] ctl,
  output logic [3:0]  alu_ctl
);

  always_comb begin
    ctl     = '0;
    alu_ctl = ALU_ADD;
    case (state)
      ST_FETCH, ST_FWAIT: begin
        ctl[CTL_READ_IP]     = 1'b1;
        ctl[CTL_MEM_ADDR_RG] = 1'b1;
      end
      ST_INCR: begin
        ctl[CTL_READ_IP]     = 1'b1;
        ctl[CTL_ALU_INCR_IP] = 1'b1;
        ctl[CTL_REG_WRITE]   = 1'b1;
      end
      ST_EXEC: begin
        case (opcode)
          OP_ALU: begin
            ctl[CTL_REG_WRITE] = 1'b1;
            ctl[CTL_A_SRC]     = 1'b1;
            ctl[CTL_B_DEST]    = 1'b1;
            alu_ctl            = func;
          end
          OP_ALUI: begin
            ctl[CTL_REG_WRITE]   = 1'b1;
            ctl[CTL_ALU_USE_IMM] = 1'b1;
            alu_ctl              = func;
          end
          OP_MOVI: begin
            ctl[CTL_REG_WRITE] = 1'b1;
            ctl[CTL_RW_IMM]    = 1'b1;
          end
          OP_MOV: begin
            ctl[CTL_REG_WRITE] = 1'b1;
            ctl[CTL_RW_USE_B]  = 1'b1;
          end
          OP_LD: begin
            ctl[CTL_MEM_ADDR_RG] = 1'b1;
            ctl[CTL_A_SRC]       = 1'b1;
          end
          OP_ST, OP_STB: begin
            ctl[CTL_MEM_WRITE]   = 1'b1;
            ctl[CTL_B_DEST]      = 1'b1;
            ctl[CTL_ALU_USE_IMM] = 1'b1;
            ctl[CTL_A_SRC]       = 1'b1;
            ctl[CTL_MEM_BYTE]    = (opcode == OP_STB);
          end
          OP_JMP: begin
            ctl[CTL_READ_IP]   = 1'b1;
            ctl[CTL_REG_WRITE] = 1'b1;
            ctl[CTL_RW_IMM]    = 1'b1;
          end
          OP_BT, OP_BF: begin
            ctl[CTL_READ_IP]     = 1'b1;
            ctl[CTL_RW_IMM]      = 1'b1;
            ctl[CTL_RW_IF_TRUE]  = (opcode == OP_BT);
            ctl[CTL_RW_IF_FALSE] = (opcode == OP_BF);
          end
          OP_OUT: begin
            ctl[CTL_REG_WRITE] = 1'b1;
            ctl[CTL_RW_OUT]    = 1'b1;
            ctl[CTL_RW_USE_B]  = 1'b1;
          end
          OP_SW: begin
            ctl[CTL_REG_WRITE]   = 1'b1;
            ctl[CTL_READ_SWITCH] = 1'b1;
          end
          default: ;
        endcase
      end
      ST_LWAIT: begin
        ctl[CTL_MEM_ADDR_RG] = 1'b1;
        ctl[CTL_A_SRC]       = 1'b1;
      end
      ST_WB: begin
        ctl[CTL_REG_WRITE] = 1'b1;
        ctl[CTL_RW_MEM]    = 1'b1;
      end
      // Only stores reach SWAIT, so the store flags are simply held here.
      ST_SWAIT: begin
        ctl[CTL_MEM_WRITE]   = 1'b1;
        ctl[CTL_B_DEST]      = 1'b1;
        ctl[CTL_ALU_USE_IMM] = 1'b1;
        ctl[CTL_A_SRC]       = 1'b1;
        ctl[CTL_MEM_BYTE]    = (opcode == OP_STB);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle instruction controller: fetch, IP increment, decode, per-opcode datapath sequencing.
// Latency: 4+ cycles per instruction; every output registered, ctl aligned with state entry.
// Backpressure: stalls indefinitely on mem_ready (fetch/load) and mem_write_done (store).
module control_fsm
  import cpu_defs::*;
#(
  parameter bit IMM_SIGNED = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        mem_write_done,
  input  logic [31:0] reg_first,
  input  logic [31:0] reg_second,
  output logic [15:0] ctl,
  output logic [4:0]  SourceReg,
  output logic [4:0]  DestReg,
  output logic [3:0]  AluControl,
  output logic [31:0] Immediate,
  output logic        halted
);

  state_e      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [3:0]  func_q, func_d;
  logic [4:0]  src_q, src_d;
  logic [4:0]  dest_q, dest_d;
  logic [31:0] imm_q, imm_d;
  logic [15:0] ctl_q, ctl_d;
  logic [3:0]  alu_q, alu_d;
  logic        halted_q, halted_d;

  // Register values are carried for debug/branch use only; sequencing ignores them.
  logic unused_regs;
  assign unused_regs = ^{reg_first, reg_second};

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    func_d  = func_q;
    src_d   = src_q;
    dest_d  = dest_q;
    imm_d   = imm_q;
    case (state_q)
      ST_FETCH: state_d = ST_FWAIT;
      ST_FWAIT: begin
        if (mem_ready) begin
          state_d = ST_INCR;
          op_d    = instr[31:26];
          dest_d  = instr[25:21];
          src_d   = instr[20:16];
          func_d  = instr[3:0];
          imm_d   = IMM_SIGNED ? {{16{instr[15]}}, instr[15:0]} : {16'h0000, instr[15:0]};
        end
      end
      ST_INCR: state_d = ST_EXEC;
      ST_EXEC: begin
        case (op_q)
          OP_LD:         state_d = ST_LWAIT;
          OP_ST, OP_STB: state_d = ST_SWAIT;
          OP_HALT:       state_d = ST_HALT;
          default:       state_d = ST_FETCH;
        endcase
      end
      ST_LWAIT: if (mem_ready) state_d = ST_WB;
      ST_WB:    state_d = ST_FETCH;
      ST_SWAIT: if (mem_write_done) state_d = ST_FETCH;
      default:  state_d = ST_HALT;
    endcase
    halted_d = halted_q | (state_d == ST_HALT);
  end

  // Decoding the next state lets the registered flags line up with the state they belong to.
  control_decode u_decode (
    .state   (state_d),
    .opcode  (op_q),
    .func    (func_q),
    .ctl     (ctl_d),
    .alu_ctl (alu_d)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      op_q     <= OP_NOP;
      func_q   <= 4'd0;
      src_q    <= 5'd0;
      dest_q   <= 5'd0;
      imm_q    <= 32'd0;
      ctl_q    <= 16'd0;
      alu_q    <= ALU_ADD;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      func_q   <= func_d;
      src_q    <= src_d;
      dest_q   <= dest_d;
      imm_q    <= imm_d;
      ctl_q    <= ctl_d;
      alu_q    <= alu_d;
      halted_q <= halted_d;
    end
  end

  assign ctl        = ctl_q;
  assign SourceReg  = src_q;
  assign DestReg    = dest_q;
  assign AluControl = alu_q;
  assign Immediate  = imm_q;
  assign halted     = halted_q;

endmodule
